// File: rtl/ddr3_rd_pkg.sv
// Shared types and constants for the DDR3 read-data serialiser: FSM states,
// beat/byte geometry helpers and the optional status-byte layout.
package ddr3_rd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_SEND = 2'd2
    } state_e;

    localparam int DEF_WIDTH      = 128;
    localparam int BYTES_PER_BEAT = DEF_WIDTH / 8;
    localparam int BYTE_IDX_W     = $clog2(BYTES_PER_BEAT);

    // Status byte emitted ahead of each burst when the header feature is built in.
    typedef struct packed {
        logic       ovf;
        logic [2:0] rsvd;
        logic [3:0] seq;
    } status_t;

    function automatic int bytes_per_beat(input int width);
        return width / 8;
    endfunction

    function automatic int byte_idx_width(input int width);
        return ((width / 8) > 1) ? $clog2(width / 8) : 1;
    endfunction

    function automatic logic [7:0] status_byte(input logic ovf, input logic [3:0] seq);
        status_t s;
        s.ovf  = ovf;
        s.rsvd = 3'b000;
        s.seq  = seq;
        return s;
    endfunction

endpackage

// File: rtl/ddr3_beat_fifo.sv
// Synchronous DEPTH x DW beat buffer with occupancy count; a push is accepted
// when full only if a pop happens in the same cycle. Head entry is read combinationally.
module ddr3_beat_fifo #(
    parameter int DW    = 129,
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push_i,
    input  logic [DW-1:0]            din_i,
    input  logic                     pop_i,
    output logic [DW-1:0]            dout_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rptr_q;
    logic [CW-1:0] count_q;
    logic          pop_ok_s;
    logic          push_ok_s;

    assign pop_ok_s  = pop_i & (count_q != CW'(0));
    assign push_ok_s = push_i & ((count_q < CW'(DEPTH)) | pop_ok_s);

    // Pointer and occupancy registers; pointers wrap naturally as DEPTH is a power of two.
    always_ff @(posedge clock) begin
        if (reset) begin
            wptr_q  <= {AW{1'b0}};
            rptr_q  <= {AW{1'b0}};
            count_q <= {CW{1'b0}};
        end else begin
            if (push_ok_s) wptr_q <= wptr_q + AW'(1);
            if (pop_ok_s)  rptr_q <= rptr_q + AW'(1);
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage array; contents need no reset since the count qualifies them.
    always_ff @(posedge clock) begin
        if (push_ok_s) mem_q[wptr_q] <= din_i;
    end

    assign dout_o  = mem_q[rptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/ddr3_rd_serialiser.sv
// Buffers non-throttleable DDR3 read beats and streams them MSB-first as bytes on AXI4-Stream.
// Optional macro DDR3_RD_SERIALISER_STATUS_EN prefixes each burst with a status byte.
module ddr3_rd_serialiser
    import ddr3_rd_pkg::*;
#(
    parameter int WIDTH       = 128,
    parameter int DEPTH       = 4,
    parameter int BURST_BEATS = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             rd_valid_i,
    input  logic             rd_last_i,
    input  logic [WIDTH-1:0] rd_data_i,
    output logic             credit_o,
    output logic             overflow_o,
    output logic             m_tvalid_o,
    input  logic             m_tready_i,
    output logic             m_tlast_o,
    output logic [7:0]       m_tdata_o
);
    localparam int BPB = bytes_per_beat(WIDTH);
    localparam int IW  = byte_idx_width(WIDTH);
    localparam int CW  = $clog2(DEPTH) + 1;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             flag_q, flag_d;
    logic             credit_q, credit_d;
    logic             overflow_q, overflow_d;
`ifdef DDR3_RD_SERIALISER_STATUS_EN
    logic [3:0]       seq_q, seq_d;
    logic             hdr_due_q, hdr_due_d;
`endif

    logic [WIDTH:0]   head_s;
    logic [CW-1:0]    count_s;
    logic             pop_s;
    logic             push_s;
    logic             load_s;
    logic             last_byte_s;

    ddr3_beat_fifo #(
        .DW    (WIDTH + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (push_s),
        .din_i   ({rd_last_i, rd_data_i}),
        .pop_i   (pop_s),
        .dout_o  (head_s),
        .count_o (count_s)
    );

    assign last_byte_s = (idx_q == IW'(BPB - 1));

    // Next-state logic: byte sequencing, beat reload without bubble, buffer admission, credit.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        idx_d      = idx_q;
        flag_d     = flag_q;
        pop_s      = 1'b0;
        load_s     = 1'b0;
`ifdef DDR3_RD_SERIALISER_STATUS_EN
        seq_d      = seq_q;
        hdr_due_d  = hdr_due_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (count_s != CW'(0)) load_s = 1'b1;
                else                   state_d = ST_IDLE;
            end
            ST_HDR: begin
                if (m_tready_i) begin
                    state_d = ST_SEND;
`ifdef DDR3_RD_SERIALISER_STATUS_EN
                    seq_d   = seq_q + 4'd1;
`endif
                end else begin
                    state_d = ST_HDR;
                end
            end
            ST_SEND: begin
                if (m_tready_i) begin
                    shift_d = {shift_q[WIDTH-9:0], 8'h00};
                    if (last_byte_s) begin
                        if (count_s != CW'(0)) load_s = 1'b1;
                        else                   state_d = ST_IDLE;
                    end else begin
                        idx_d = idx_q + IW'(1);
                    end
                end else begin
                    state_d = ST_SEND;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (load_s) begin
            pop_s     = 1'b1;
            shift_d   = head_s[WIDTH-1:0];
            flag_d    = head_s[WIDTH];
            idx_d     = {IW{1'b0}};
`ifdef DDR3_RD_SERIALISER_STATUS_EN
            state_d   = hdr_due_q ? ST_HDR : ST_SEND;
            hdr_due_d = head_s[WIDTH];
`else
            state_d   = ST_SEND;
`endif
        end else begin
            pop_s = 1'b0;
        end

        push_s     = rd_valid_i & ((count_s < CW'(DEPTH)) | pop_s);
        overflow_d = overflow_q | (rd_valid_i & ~push_s);
        credit_d   = ((int'(count_s) + BURST_BEATS) <= DEPTH);
    end

    // State and datapath registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            shift_q    <= {WIDTH{1'b0}};
            idx_q      <= {IW{1'b0}};
            flag_q     <= 1'b0;
            credit_q   <= 1'b1;
            overflow_q <= 1'b0;
`ifdef DDR3_RD_SERIALISER_STATUS_EN
            seq_q      <= 4'd0;
            hdr_due_q  <= 1'b1;
`endif
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            idx_q      <= idx_d;
            flag_q     <= flag_d;
            credit_q   <= credit_d;
            overflow_q <= overflow_d;
`ifdef DDR3_RD_SERIALISER_STATUS_EN
            seq_q      <= seq_d;
            hdr_due_q  <= hdr_due_d;
`endif
        end
    end

    assign m_tvalid_o = (state_q != ST_IDLE);
    assign m_tlast_o  = (state_q == ST_SEND) & flag_q & last_byte_s;
    assign credit_o   = credit_q;
    assign overflow_o = overflow_q;
`ifdef DDR3_RD_SERIALISER_STATUS_EN
    assign m_tdata_o  = (state_q == ST_HDR) ? status_byte(overflow_q, seq_q) : shift_q[WIDTH-1 -: 8];
`else
    assign m_tdata_o  = shift_q[WIDTH-1 -: 8];
`endif

endmodule

// File: tb/tb_ddr3_rd_serialiser.sv
// Directed self-checking bench for ddr3_rd_serialiser (default build, DEPTH=4, BURST_BEATS=1).
module tb_ddr3_rd_serialiser;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         rd_valid_i = 1'b0;
    logic         rd_last_i = 1'b0;
    logic [127:0] rd_data_i = 128'd0;
    logic         credit_o;
    logic         overflow_o;
    logic         m_tvalid_o;
    logic         m_tready_i = 1'b0;
    logic         m_tlast_o;
    logic [7:0]   m_tdata_o;

    int n_chk  = 0;
    int n_fail = 0;

    logic [128:0] beat_q [$];
    logic [8:0]   exp_q  [$];

    typedef struct {
        logic         v;
        logic         l;
        logic [127:0] d;
        logic         rdy;
        logic         e_tvalid;
        logic         e_tlast;
        logic [7:0]   e_tdata;
        logic         e_credit;
        logic         e_ovf;
    } vec_t;

    vec_t tbl [20];

    ddr3_rd_serialiser #(.WIDTH(128), .DEPTH(4), .BURST_BEATS(1)) dut (
        .clock      (clock),
        .reset      (reset),
        .rd_valid_i (rd_valid_i),
        .rd_last_i  (rd_last_i),
        .rd_data_i  (rd_data_i),
        .credit_o   (credit_o),
        .overflow_o (overflow_o),
        .m_tvalid_o (m_tvalid_o),
        .m_tready_i (m_tready_i),
        .m_tlast_o  (m_tlast_o),
        .m_tdata_o  (m_tdata_o)
    );

    always #5 clock = ~clock;

    // Beat whose byte k (counting from the MSB) is base+k.
    function automatic logic [127:0] mkbeat(input logic [7:0] base);
        logic [127:0] d;
        d = 128'd0;
        for (int k = 0; k < 16; k++) d[127 - 8*k -: 8] = base + 8'(k);
        return d;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic add_beat(input logic [7:0] base, input logic last, input bit to_dut);
        if (to_dut) beat_q.push_back({last, mkbeat(base)});
        for (int k = 0; k < 16; k++) exp_q.push_back({last && (k == 15), base + 8'(k)});
    endtask

    task automatic do_reset();
        reset      = 1'b1;
        rd_valid_i = 1'b0;
        m_tready_i = 1'b0;
        beat_q.delete();
        exp_q.delete();
        repeat (2) @(negedge clock);
        reset = 1'b0;
    endtask

    // Feed beat_q, consume exp_q; mode 0 = always ready, mode 1 = ready pattern 1,0,0.
    task automatic run(input int total, input int mode, input bit gapchk, input int budget);
        int         n = 0;
        int         cyc = 0;
        int         ph = 0;
        logic       rdy;
        logic       prev_stall = 1'b0;
        logic [7:0] pd = 8'd0;
        logic       pl = 1'b0;
        logic [8:0] e;
        while ((n < total || beat_q.size() != 0) && cyc < budget) begin
            if (prev_stall) begin
                chk("stall_valid", {31'd0, m_tvalid_o}, 32'd1);
                chk("stall_data", {24'd0, m_tdata_o}, {24'd0, pd});
                chk("stall_last", {31'd0, m_tlast_o}, {31'd0, pl});
            end
            if (gapchk && n > 0 && n < total) chk("no_gap", {31'd0, m_tvalid_o}, 32'd1);
            rdy = (mode == 0) ? 1'b1 : (ph % 3 == 0);
            ph++;
            m_tready_i = rdy;
            if (m_tvalid_o && rdy) begin
                if (exp_q.size() == 0) begin
                    chk("extra_byte", {24'd0, m_tdata_o}, 32'hFFFF_FFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("byte_data", {24'd0, m_tdata_o}, {24'd0, e[7:0]});
                    chk("byte_last", {31'd0, m_tlast_o}, {31'd0, e[8]});
                end
                n++;
            end
            prev_stall = m_tvalid_o & ~rdy;
            pd = m_tdata_o;
            pl = m_tlast_o;
            if (beat_q.size() != 0) begin
                rd_valid_i = 1'b1;
                {rd_last_i, rd_data_i} = beat_q.pop_front();
            end else begin
                rd_valid_i = 1'b0;
            end
            @(negedge clock);
            cyc++;
        end
        if (cyc >= budget) chk("run_timeout", 32'(n), 32'(total));
        rd_valid_i = 1'b0;
        m_tready_i = 1'b1;
        repeat (3) begin
            @(negedge clock);
            chk("idle_after", {31'd0, m_tvalid_o}, 32'd0);
        end
        chk("bytes_left", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int        found;
        logic [7:0] b;

        for (int i = 0; i < 20; i++) begin
            tbl[i].v        = (i == 0);
            tbl[i].l        = 1'b1;
            tbl[i].d        = mkbeat(8'h00);
            tbl[i].rdy      = 1'b1;
            tbl[i].e_tvalid = (i >= 2 && i <= 17);
            tbl[i].e_tdata  = (i >= 2 && i <= 17) ? 8'(i - 2) : 8'h00;
            tbl[i].e_tlast  = (i == 17);
            tbl[i].e_credit = 1'b1;
            tbl[i].e_ovf    = 1'b0;
        end

        do_reset();
        chk("rst_tvalid", {31'd0, m_tvalid_o}, 32'd0);
        chk("rst_tlast", {31'd0, m_tlast_o}, 32'd0);
        chk("rst_tdata", {24'd0, m_tdata_o}, 32'd0);
        chk("rst_credit", {31'd0, credit_o}, 32'd1);
        chk("rst_ovf", {31'd0, overflow_o}, 32'd0);

        // Single beat: latency N+2, bytes 00..0F, tlast on the last one.
        for (int i = 0; i < 20; i++) begin
            chk($sformatf("t1_tvalid[%0d]", i), {31'd0, m_tvalid_o}, {31'd0, tbl[i].e_tvalid});
            chk($sformatf("t1_tdata[%0d]", i), {24'd0, m_tdata_o}, {24'd0, tbl[i].e_tdata});
            chk($sformatf("t1_tlast[%0d]", i), {31'd0, m_tlast_o}, {31'd0, tbl[i].e_tlast});
            chk($sformatf("t1_credit[%0d]", i), {31'd0, credit_o}, {31'd0, tbl[i].e_credit});
            chk($sformatf("t1_ovf[%0d]", i), {31'd0, overflow_o}, {31'd0, tbl[i].e_ovf});
            rd_valid_i = tbl[i].v;
            rd_last_i  = tbl[i].l;
            rd_data_i  = tbl[i].d;
            m_tready_i = tbl[i].rdy;
            @(negedge clock);
        end

        // Four back-to-back beats, one burst: 64 contiguous bytes.
        do_reset();
        add_beat(8'h00, 1'b0, 1'b1);
        add_beat(8'h10, 1'b0, 1'b1);
        add_beat(8'h20, 1'b0, 1'b1);
        add_beat(8'h30, 1'b1, 1'b1);
        run(64, 0, 1'b1, 200);

        // Backpressure with ready 1,0,0 repeating.
        do_reset();
        add_beat(8'h30, 1'b1, 1'b1);
        run(16, 1, 1'b0, 200);

        // Overflow: ready held low; shift register plus 4 entries hold 5 beats, the 6th drops.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            if (i == 5) begin
                chk("ovf_before", {31'd0, overflow_o}, 32'd0);
                chk("credit_before_full", {31'd0, credit_o}, 32'd1);
            end
            rd_valid_i = 1'b1;
            rd_last_i  = (i == 4);
            rd_data_i  = mkbeat(8'(8'h10 * (i + 1)));
            @(negedge clock);
        end
        rd_valid_i = 1'b0;
        chk("ovf_set", {31'd0, overflow_o}, 32'd1);
        chk("credit_full", {31'd0, credit_o}, 32'd0);
        @(negedge clock);
        chk("ovf_sticky", {31'd0, overflow_o}, 32'd1);
        add_beat(8'h10, 1'b0, 1'b0);
        add_beat(8'h20, 1'b0, 1'b0);
        add_beat(8'h30, 1'b0, 1'b0);
        add_beat(8'h40, 1'b0, 1'b0);
        add_beat(8'h50, 1'b1, 1'b0);
        run(80, 0, 1'b1, 300);
        chk("ovf_sticky_end", {31'd0, overflow_o}, 32'd1);
        chk("credit_drained", {31'd0, credit_o}, 32'd1);

        // Full buffer: push in the same cycle as the head beat's final byte is accepted.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            rd_valid_i = 1'b1;
            rd_last_i  = (i == 4);
            rd_data_i  = mkbeat(8'(8'h80 + 8'h10 * i));
            @(negedge clock);
        end
        rd_valid_i = 1'b0;
        @(negedge clock);
        chk("pp_credit_full", {31'd0, credit_o}, 32'd0);
        m_tready_i = 1'b1;
        for (int k = 0; k < 15; k++) begin
            b = 8'h80 + 8'(k);
            chk("pp_head_byte", {24'd0, m_tdata_o}, {24'd0, b});
            @(negedge clock);
        end
        chk("pp_head_b15", {24'd0, m_tdata_o}, 32'h8F);
        chk("pp_head_nolast", {31'd0, m_tlast_o}, 32'd0);
        rd_valid_i = 1'b1;
        rd_last_i  = 1'b1;
        rd_data_i  = mkbeat(8'hD0);
        @(negedge clock);
        rd_valid_i = 1'b0;
        m_tready_i = 1'b0;
        chk("pp_no_ovf", {31'd0, overflow_o}, 32'd0);
        chk("pp_reload_nobubble", {31'd0, m_tvalid_o}, 32'd1);
        chk("pp_next_head", {24'd0, m_tdata_o}, 32'h90);
        @(negedge clock);
        chk("pp_count_held", {31'd0, credit_o}, 32'd0);
        add_beat(8'h90, 1'b0, 1'b0);
        add_beat(8'hA0, 1'b0, 1'b0);
        add_beat(8'hB0, 1'b0, 1'b0);
        add_beat(8'hC0, 1'b1, 1'b0);
        add_beat(8'hD0, 1'b1, 1'b0);
        run(80, 0, 1'b1, 300);
        chk("pp_no_ovf_end", {31'd0, overflow_o}, 32'd0);

        // Reset at byte 7 of the second beat, then a fresh beat.
        do_reset();
        m_tready_i = 1'b1;
        rd_valid_i = 1'b1;
        rd_last_i  = 1'b0;
        rd_data_i  = mkbeat(8'h00);
        @(negedge clock);
        rd_data_i  = mkbeat(8'hA0);
        @(negedge clock);
        rd_valid_i = 1'b0;
        found = 0;
        for (int c = 0; c < 60 && found == 0; c++) begin
            if (m_tvalid_o && m_tdata_o == 8'hA7) found = 1;
            else @(negedge clock);
        end
        chk("mid_reach_b7", 32'(found), 32'd1);
        reset = 1'b1;
        @(negedge clock);
        chk("mid_tvalid", {31'd0, m_tvalid_o}, 32'd0);
        chk("mid_credit", {31'd0, credit_o}, 32'd1);
        chk("mid_ovf", {31'd0, overflow_o}, 32'd0);
        chk("mid_tdata", {24'd0, m_tdata_o}, 32'd0);
        reset = 1'b0;
        @(negedge clock);
        chk("mid_still_idle", {31'd0, m_tvalid_o}, 32'd0);
        add_beat(8'h70, 1'b1, 1'b1);
        run(16, 0, 1'b1, 100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
